obj_stream_loader: RTL and testbench

// - Hardware front end that loads a PAL object image into PDP-8 memory, then starts the CPU.
// - Sits upstream of Top/MEM0. Consumes a byte stream of 8-bit frames (UART RX or a host model).
// - Drives the same memory-bus write handshake as the front-panel Deposit path, and the same Load PC path.
// - Replaces the switch/button load sequence.

---
 rtl/obj_stream_loader_pkg.sv | 18 +
 rtl/obj_frame_assembler.sv | 40 ++++
 rtl/obj_stream_loader.sv | 160 ++++++++++++++++
 tb/tb_obj_stream_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obj_stream_loader_pkg.sv
// Shared types for the PAL object-stream loader: word type, loader FSM states
// and object-frame bit positions.
package obj_stream_loader_pkg;

  typedef logic [11:0] word_t;

  typedef enum logic [2:0] {
    LD_HIGH,
    LD_LOW,
    LD_WRITE,
    LD_START,
    LD_RUN
  } loader_state_t;

  localparam int FRAME_LEADER_BIT = 7;
  localparam int FRAME_ORIGIN_BIT = 6;

endpackage

// File: rtl/obj_frame_assembler.sv
// Pairs high/low object frames into 12-bit words; holds the high frame and
// decodes leader/trailer and origin markers for the loader FSM.
module obj_frame_assembler
  import obj_stream_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_fire,
  input  logic       expect_low,
  input  logic [7:0] frame_data,
  output logic       hi_load,
  output logic       pair_error,
  output logic       word_valid,
  output logic       word_is_origin,
  output word_t      word
);

  logic [6:0] hi_q;
  logic [6:0] hi_d;
  logic       is_leader;

  always_comb begin
    is_leader      = frame_data[FRAME_LEADER_BIT];
    hi_load        = frame_fire && !expect_low && !is_leader;
    pair_error     = frame_fire && expect_low && is_leader;
    word_valid     = frame_fire && expect_low && !is_leader;
    word_is_origin = hi_q[FRAME_ORIGIN_BIT];
    word           = {hi_q[5:0], frame_data[5:0]};
    hi_d           = hi_load ? frame_data[6:0] : hi_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
    end else begin
      hi_q <= hi_d;
    end
  end

endmodule

// File: rtl/obj_stream_loader.sv
// Loads a PAL object image from a byte-frame stream into PDP-8 memory using
// the Deposit write handshake, then pulses Load PC and enables run.
module obj_stream_loader
  import obj_stream_loader_pkg::*;
#(
  parameter logic [11:0] START_PC = 12'o0200,
  parameter int          COUNT_W  = 13
) (
  input  logic               clk,
  input  logic               btnCpuReset,
  input  logic               frame_valid,
  input  logic [7:0]         frame_data,
  output logic               frame_ready,
  input  logic               stream_eof,
  output logic [11:0]        mem_address,
  output logic [11:0]        mem_write_data,
  output logic               mem_write_en,
  input  logic               mem_finished,
  output logic               load_pc,
  output logic [11:0]        pc_value,
  output logic               run,
  output logic               load_error,
  output logic [COUNT_W-1:0] word_count
);

  loader_state_t      state_q, state_d, mid_state;
  word_t              addr_q, addr_d;
  word_t              mem_address_q, mem_address_d;
  word_t              mem_write_data_q, mem_write_data_d;
  logic               mem_write_en_q, mem_write_en_d;
  logic               frame_ready_q, frame_ready_d;
  logic               run_q, run_d;
  logic               load_error_q, load_error_d;
  logic               eof_pend_q, eof_pend_d;
  logic [COUNT_W-1:0] word_count_q, word_count_d;

  logic  frame_fire;
  logic  hi_load, pair_error, word_valid, word_is_origin;
  word_t word;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign frame_fire = frame_valid && frame_ready_q;

  obj_frame_assembler u_asm (
    .clk            (clk),
    .rst_n          (btnCpuReset),
    .frame_fire     (frame_fire),
    .expect_low     (state_q == LD_LOW),
    .frame_data     (frame_data),
    .hi_load        (hi_load),
    .pair_error     (pair_error),
    .word_valid     (word_valid),
    .word_is_origin (word_is_origin),
    .word           (word)
  );

  always_comb begin
    mid_state        = state_q;
    addr_d           = addr_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_write_en_d   = mem_write_en_q;
    run_d            = run_q;
    load_error_d     = load_error_q;
    eof_pend_d       = eof_pend_q;
    word_count_d     = word_count_q;

    case (state_q)
      LD_HIGH: begin
        if (hi_load) mid_state = LD_LOW;
      end
      LD_LOW: begin
        if (pair_error) begin
          load_error_d = 1'b1;
          mid_state    = LD_HIGH;
        end else if (word_valid) begin
          if (word_is_origin) begin
            addr_d    = word;
            mid_state = LD_HIGH;
          end else begin
            mem_write_data_d = word;
            mem_address_d    = addr_q;
            mem_write_en_d   = 1'b1;
            mid_state        = LD_WRITE;
          end
        end
      end
      LD_WRITE: begin
        if (mem_finished) begin
          mem_write_en_d = 1'b0;
          addr_d         = addr_q + 12'd1;
          word_count_d   = sat_inc(word_count_q);
          eof_pend_d     = 1'b0;
          mid_state      = eof_pend_q ? LD_START : LD_HIGH;
        end
      end
      LD_START: begin
        run_d     = 1'b1;
        mid_state = LD_RUN;
      end
      default: ;
    endcase

    // End-of-stream acts on the state reached after any same-cycle frame.
    state_d = mid_state;
    if (stream_eof) begin
      case (mid_state)
        LD_HIGH:  state_d = LD_START;
        LD_LOW: begin
          load_error_d = 1'b1;
          state_d      = LD_START;
        end
        LD_WRITE: eof_pend_d = 1'b1;
        default: ;
      endcase
    end

    frame_ready_d = (state_d == LD_HIGH) || (state_d == LD_LOW);
  end

  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state_q          <= LD_HIGH;
      addr_q           <= '0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_write_en_q   <= 1'b0;
      frame_ready_q    <= 1'b0;
      run_q            <= 1'b0;
      load_error_q     <= 1'b0;
      eof_pend_q       <= 1'b0;
      word_count_q     <= '0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_write_en_q   <= mem_write_en_d;
      frame_ready_q    <= frame_ready_d;
      run_q            <= run_d;
      load_error_q     <= load_error_d;
      eof_pend_q       <= eof_pend_d;
      word_count_q     <= word_count_d;
    end
  end

  assign frame_ready    = frame_ready_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_write_en   = mem_write_en_q;
  assign load_pc        = (state_q == LD_START);
  assign pc_value       = START_PC;
  assign run            = run_q;
  assign load_error     = load_error_q;
  assign word_count     = word_count_q;

endmodule

// File: tb/tb_obj_stream_loader.sv
// Directed bench for obj_stream_loader with a handshaking memory model and
// load_pc monitor.
module tb_obj_stream_loader;

  logic        clk = 1'b0;
  logic        btnCpuReset;
  logic        frame_valid;
  logic [7:0]  frame_data;
  logic        frame_ready;
  logic        stream_eof;
  logic [11:0] mem_address;
  logic [11:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_finished = 1'b0;
  logic        load_pc;
  logic [11:0] pc_value;
  logic        run;
  logic        load_error;
  logic [12:0] word_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  obj_stream_loader dut (
    .clk            (clk),
    .btnCpuReset    (btnCpuReset),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .frame_ready    (frame_ready),
    .stream_eof     (stream_eof),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_finished   (mem_finished),
    .load_pc        (load_pc),
    .pc_value       (pc_value),
    .run            (run),
    .load_error     (load_error),
    .word_count     (word_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o, expected %0o", tag, obs, exp);
    end
  endtask

  // Memory model: completes each write after mem_delay cycles of mem_write_en.
  int          mem_delay = 1;
  int          en_cnt, en_max, nwr, ready_in_en, npc, cyc, fin_cyc, pc_cyc;
  logic [11:0] wr_addr [8];
  logic [11:0] wr_data [8];
  logic [11:0] pc_seen;

  always @(negedge clk) begin
    cyc++;
    if (!btnCpuReset) begin
      en_cnt = 0; en_max = 0; nwr = 0; ready_in_en = 0;
      npc = 0; pc_seen = '0; fin_cyc = 0; pc_cyc = 0;
      mem_finished = 1'b0;
    end else begin
      if (mem_write_en) begin
        en_cnt++;
        if (en_cnt > en_max) en_max = en_cnt;
        if (frame_ready) ready_in_en++;
        if (en_cnt == 1 && nwr < 8) begin
          wr_addr[nwr] = mem_address;
          wr_data[nwr] = mem_write_data;
          nwr++;
        end
        if (en_cnt == mem_delay) begin
          mem_finished = 1'b1;
          fin_cyc = cyc;
        end else begin
          mem_finished = 1'b0;
        end
      end else begin
        en_cnt = 0;
        mem_finished = 1'b0;
      end
      if (load_pc) begin
        npc++;
        pc_seen = pc_value;
        pc_cyc = cyc;
      end
    end
  end

  task automatic do_reset();
    btnCpuReset = 1'b0;
    frame_valid = 1'b0;
    frame_data  = '0;
    stream_eof  = 1'b0;
    mem_delay   = 1;
    repeat (2) @(negedge clk);
    btnCpuReset = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d);
    int n;
    n = 0;
    frame_valid = 1'b1;
    frame_data  = d;
    while (!frame_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("frame_accept_timeout", 32'(frame_ready), 32'd1);
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic pulse_eof();
    stream_eof = 1'b1;
    @(negedge clk);
    stream_eof = 1'b0;
  endtask

  task automatic wait_run();
    int n;
    n = 0;
    while (!run && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    btnCpuReset = 1'b0;
    frame_valid = 1'b0;
    frame_data  = '0;
    stream_eof  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_frame_ready", 32'(frame_ready), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_wdata", 32'(mem_write_data), 32'd0);
    check("rst_mem_we", 32'(mem_write_en), 32'd0);
    check("rst_load_pc", 32'(load_pc), 32'd0);
    check("rst_pc_value", 32'(pc_value), 32'o0200);
    check("rst_run", 32'(run), 32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);

    // Origin 0100 then data 0007
    do_reset();
    send_frame(8'o101); send_frame(8'o000);
    send_frame(8'o000); send_frame(8'o007);
    repeat (5) @(negedge clk);
    check("org_nwr", 32'(nwr), 32'd1);
    check("org_addr", 32'(wr_addr[0]), 32'o0100);
    check("org_data", 32'(wr_data[0]), 32'o0007);
    check("org_count", 32'(word_count), 32'd1);
    check("org_err", 32'(load_error), 32'd0);

    // Address wrap 7777 -> 0000
    do_reset();
    send_frame(8'o177); send_frame(8'o077);
    send_frame(8'o012); send_frame(8'o034);
    send_frame(8'o056); send_frame(8'o070);
    repeat (5) @(negedge clk);
    check("wrap_nwr", 32'(nwr), 32'd2);
    check("wrap_addr0", 32'(wr_addr[0]), 32'o7777);
    check("wrap_data0", 32'(wr_data[0]), 32'o1234);
    check("wrap_addr1", 32'(wr_addr[1]), 32'o0000);
    check("wrap_data1", 32'(wr_data[1]), 32'o5670);
    check("wrap_count", 32'(word_count), 32'd2);

    // Leader frames dropped; leader as low frame flags error
    do_reset();
    repeat (5) send_frame(8'o200);
    send_frame(8'o000); send_frame(8'o011);
    repeat (3) @(negedge clk);
    check("lead_err_clean", 32'(load_error), 32'd0);
    send_frame(8'o022); send_frame(8'o200);
    send_frame(8'o033); send_frame(8'o044);
    repeat (5) @(negedge clk);
    check("lead_err_set", 32'(load_error), 32'd1);
    check("lead_nwr", 32'(nwr), 32'd2);
    check("lead_data0", 32'(wr_data[0]), 32'o0011);
    check("lead_addr1", 32'(wr_addr[1]), 32'o0001);
    check("lead_data1", 32'(wr_data[1]), 32'o3344);

    // Slow memory
    do_reset();
    mem_delay = 7;
    send_frame(8'o012); send_frame(8'o034);
    repeat (15) @(negedge clk);
    check("slow_en_cycles", 32'(en_max), 32'd7);
    check("slow_ready_in_en", 32'(ready_in_en), 32'd0);
    check("slow_nwr", 32'(nwr), 32'd1);
    check("slow_data", 32'(wr_data[0]), 32'o1234);
    check("slow_count", 32'(word_count), 32'd1);

    // Slow memory with eof mid-write
    do_reset();
    mem_delay = 7;
    send_frame(8'o043); send_frame(8'o021);
    repeat (2) @(negedge clk);
    pulse_eof();
    wait_run();
    repeat (2) @(negedge clk);
    check("eofw_nwr", 32'(nwr), 32'd1);
    check("eofw_en_cycles", 32'(en_max), 32'd7);
    check("eofw_load_pc_n", 32'(npc), 32'd1);
    check("eofw_pc_value", 32'(pc_seen), 32'o0200);
    check("eofw_pc_after_wr", 32'(pc_cyc > fin_cyc), 32'd1);
    check("eofw_run", 32'(run), 32'd1);
    check("eofw_err", 32'(load_error), 32'd0);
    check("eofw_count", 32'(word_count), 32'd1);

    // Eof after a lone high frame
    do_reset();
    send_frame(8'o001);
    pulse_eof();
    wait_run();
    repeat (2) @(negedge clk);
    check("odd_err", 32'(load_error), 32'd1);
    check("odd_nwr", 32'(nwr), 32'd0);
    check("odd_load_pc_n", 32'(npc), 32'd1);
    check("odd_run", 32'(run), 32'd1);
    check("odd_ready_in_run", 32'(frame_ready), 32'd0);
    check("odd_load_pc_low", 32'(load_pc), 32'd0);

    // Reset while a write is pending
    do_reset();
    mem_delay = 1000;
    send_frame(8'o105); send_frame(8'o000);
    send_frame(8'o011); send_frame(8'o022);
    @(negedge clk);
    check("rmw_we_before", 32'(mem_write_en), 32'd1);
    check("rmw_addr_before", 32'(mem_address), 32'o0500);
    check("rmw_data_before", 32'(mem_write_data), 32'o1122);
    #2;
    btnCpuReset = 1'b0;
    #1;
    check("rmw_we", 32'(mem_write_en), 32'd0);
    check("rmw_addr", 32'(mem_address), 32'd0);
    check("rmw_data", 32'(mem_write_data), 32'd0);
    check("rmw_ready", 32'(frame_ready), 32'd0);
    check("rmw_run", 32'(run), 32'd0);
    check("rmw_count", 32'(word_count), 32'd0);
    do_reset();
    send_frame(8'o033); send_frame(8'o044);
    repeat (5) @(negedge clk);
    check("rmw_next_nwr", 32'(nwr), 32'd1);
    check("rmw_next_addr", 32'(wr_addr[0]), 32'o0000);
    check("rmw_next_data", 32'(wr_data[0]), 32'o3344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
